adsr_envelope: RTL and testbench
================================

// Module: adsr_envelope
// PURPOSE
//  Parametrised ADSR envelope generator and sample multiplier; next generation of adsr.
//  Runs a gate-driven 5-state envelope with per-note runtime-programmable rates and
//  sustain, and scales each incoming signed sample by the current envelope level.
//  Sits between the tone/wave generator and the codec output path; advances on sample strobes.
// PARAMETERS
//  SAMPLE_W  16  width of signed sample_in / sample_out
//  ENV_W     16  envelope level width; ENV_MAX = 2**ENV_W-1
//  RATE_W    16  width of attack/decay/release step inputs (RATE_W <= ENV_W)
// PORTS
//  clk            in   1         system clock
//  reset          in   1         one clock; reset is asynchronous and active-low
//  in_ready       in   1         sample strobe; one-cycle pulse per input sample
//  sample_in      in   SAMPLE_W  signed input sample, valid when in_ready=1
//  gate           in   1         note on (1) / note off (0), level-sensitive
//  attack_rate    in   RATE_W    level increment per strobe in ATTACK; 0 = instant
//  decay_rate     in   RATE_W    level decrement per strobe in DECAY; 0 = instant
//  sustain_level  in   ENV_W     DECAY target / SUSTAIN hold level
//  release_rate   in   RATE_W    level decrement per strobe in RELEASE; 0 = instant
//  sample_out     out  SAMPLE_W  signed scaled sample, registered
//  out_valid      out  1         one-cycle pulse, sample_out updated
//  env_level      out  ENV_W     current envelope level
//  env_state      out  3         IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//  busy           out  1         env_state != IDLE
// BEHAVIOUR
//  Reset (reset=0, async): env_level=0, env_state=IDLE, sample_out=0, out_valid=0,
//   busy=0, gate_d=0. A gate held high at reset release is seen as a rising edge.
//  Gate edges (gate vs gate_d, checked every clk) act immediately:
//   rise in any state -> ATTACK from current level (retrigger, no jump to 0);
//   fall in ATTACK/DECAY/SUSTAIN -> RELEASE from current level; fall in IDLE/RELEASE: no-op.
//  Level steps only on in_ready=1; rates and sustain are sampled live at each strobe:
//   ATTACK : lvl+attack_rate, saturate at ENV_MAX; reaching ENV_MAX -> DECAY.
//   DECAY  : lvl-decay_rate, floor at sustain_level; reaching it -> SUSTAIN.
//            sustain_level=ENV_MAX -> SUSTAIN on first DECAY strobe.
//   SUSTAIN: lvl tracks sustain_level (written each strobe).
//   RELEASE: lvl-release_rate, floor at 0; reaching 0 -> IDLE.
//   IDLE   : lvl held at 0.
//   Rate 0 = reach target on that strobe. Adds/subtracts computed in ENV_W+1 bits, no wrap.
//  Gate edge and in_ready in the same cycle: transition first, then the step uses the
//   new state's rate in that cycle.
//  Output: on in_ready, product = sample_in * {1'b0,env_level} (signed, SAMPLE_W+ENV_W+1),
//   sample_out = product >>> ENV_W (truncate toward -inf), using the level BEFORE
//   this strobe's step. Latency 1 clk: out_valid pulses the cycle after in_ready.
//  in_ready on consecutive cycles is legal; each strobe yields one out_valid.
// CONFIGURATION
//  ADSR_ROUND_EN defined: sample_out = (product + 2**(ENV_W-1)) >>> ENV_W (round half up),
//   saturated to the signed SAMPLE_W range. Undefined: plain truncation, no saturation logic.
//  Latency, handshake and envelope behaviour are identical in both builds.
// TESTING (SAMPLE_W=ENV_W=RATE_W=16)
//  Reset: reset=0 mid-ATTACK with level 30000 -> same cycle env_level=0, IDLE, out_valid=0.
//  ADSR run: attack=16384, decay=8192, sustain=32768, gate 0->1, strobes every 2 clk ->
//   ATTACK levels 16384,32768,49152,65535(->DECAY); DECAY 57343,49151,40959,32768
//   (->SUSTAIN); gate 1->0, release=16384 -> 16384, 0 (->IDLE, busy=0).
//  Scaling: level 65535, sample_in=16'h7FFF -> sample_out 32766 (32767 with ADSR_ROUND_EN);
//   sample_in=16'h8000 -> -32768 (-32767 with ADSR_ROUND_EN); out_valid 1 clk after in_ready.
//  Retrigger: gate falls at level 40000, one release strobe (rate 1000) -> 39000;
//   gate rises -> ATTACK, next strobe (attack 1000) -> 40000, no drop to 0.
//  Coincidence: gate rise with in_ready same cycle, attack_rate=0 -> level 65535, DECAY
//   that cycle; gate fall in IDLE -> stays IDLE, level 0.
//  Back-to-back strobes: in_ready high 8 consecutive clk -> 8 out_valid pulses, each 1 clk late.

Source files
------------

// File: rtl/adsr_envelope.sv
// adsr_envelope: gate-driven ADSR envelope generator with sample multiplier.
//
// The envelope has five states (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE). Gate edges
// change state immediately. The level only moves on in_ready strobes, using the
// rates and sustain level sampled live at that strobe. Each strobe scales sample_in
// by the level held before that strobe's step. The registered result appears one
// clock later, with a single-cycle out_valid pulse.
//
// Build option:
//   ADSR_ROUND_EN  when defined, sample_out is rounded half up and saturated to the
//                  signed SAMPLE_W range. When undefined, it is truncated toward -inf.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   in_ready       sample strobe, one-cycle pulse per input sample
//   sample_in      signed input sample, valid with in_ready
//   gate           note on (1) / note off (0), level-sensitive
//   attack_rate    level increment per strobe in ATTACK, 0 = instant
//   decay_rate     level decrement per strobe in DECAY, 0 = instant
//   sustain_level  DECAY target and SUSTAIN hold level
//   release_rate   level decrement per strobe in RELEASE, 0 = instant
//   sample_out     registered, scaled signed sample
//   out_valid      one-cycle pulse when sample_out updates
//   env_level      current envelope level
//   env_state      IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   busy           env_state != IDLE
module adsr_envelope #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned ENV_W    = 16,
    parameter int unsigned RATE_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_ready,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       gate,
    input  logic        [RATE_W-1:0]   attack_rate,
    input  logic        [RATE_W-1:0]   decay_rate,
    input  logic        [ENV_W-1:0]    sustain_level,
    input  logic        [RATE_W-1:0]   release_rate,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       out_valid,
    output logic        [ENV_W-1:0]    env_level,
    output logic        [2:0]          env_state,
    output logic                       busy
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StAttack  = 3'd1;
    localparam logic [2:0] StDecay   = 3'd2;
    localparam logic [2:0] StSustain = 3'd3;
    localparam logic [2:0] StRelease = 3'd4;

    localparam int unsigned PROD_W = SAMPLE_W + ENV_W + 1;
    localparam logic [ENV_W-1:0] ENV_MAX   = {ENV_W{1'b1}};
    localparam logic [ENV_W:0]   ENV_MAX_X = {1'b0, ENV_MAX};

    logic [ENV_W-1:0] lvl_q, lvl_d;
    logic [2:0]       state_q, state_d, state_e;
    logic             gate_q;
    logic             out_valid_q;
    logic signed [SAMPLE_W-1:0] sample_out_q;
    logic signed [SAMPLE_W-1:0] scaled;

    // Step arithmetic is one bit wider than the level so nothing wraps.
    logic [ENV_W:0] att_sum, dec_diff, rel_diff;
    assign att_sum  = {1'b0, lvl_q} + {{(ENV_W + 1 - RATE_W){1'b0}}, attack_rate};
    assign dec_diff = {1'b0, lvl_q} - {{(ENV_W + 1 - RATE_W){1'b0}}, decay_rate};
    assign rel_diff = {1'b0, lvl_q} - {{(ENV_W + 1 - RATE_W){1'b0}}, release_rate};

    always_comb begin
        // Gate edges take effect first; a same-cycle strobe then steps in the new state.
        state_e = state_q;
        if (gate && !gate_q) begin
            state_e = StAttack;
        end else if (!gate && gate_q &&
                     (state_q == StAttack || state_q == StDecay || state_q == StSustain)) begin
            state_e = StRelease;
        end

        state_d = state_e;
        lvl_d   = lvl_q;
        if (in_ready) begin
            case (state_e)
                StAttack: begin
                    if (attack_rate == '0 || att_sum >= ENV_MAX_X) begin
                        lvl_d   = ENV_MAX;
                        state_d = StDecay;
                    end else begin
                        lvl_d = att_sum[ENV_W-1:0];
                    end
                end
                StDecay: begin
                    // Borrow bit set means the subtraction went below zero.
                    if (decay_rate == '0 || dec_diff[ENV_W] ||
                        dec_diff <= {1'b0, sustain_level}) begin
                        lvl_d   = sustain_level;
                        state_d = StSustain;
                    end else begin
                        lvl_d = dec_diff[ENV_W-1:0];
                    end
                end
                StSustain: lvl_d = sustain_level;
                StRelease: begin
                    if (release_rate == '0 || rel_diff[ENV_W] || rel_diff == '0) begin
                        lvl_d   = '0;
                        state_d = StIdle;
                    end else begin
                        lvl_d = rel_diff[ENV_W-1:0];
                    end
                end
                default: begin
                    lvl_d   = '0;
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Signed multiply. The level is treated as non-negative, so it gets a zero sign bit.
    logic signed [PROD_W-1:0] samp_x, lvl_x, product;
    assign samp_x  = PROD_W'(sample_in);
    assign lvl_x   = PROD_W'($signed({1'b0, lvl_q}));
    assign product = samp_x * lvl_x;

`ifdef ADSR_ROUND_EN
    localparam int unsigned HI_W = SAMPLE_W + 2;
    localparam logic signed [HI_W-1:0] SAT_MAX = {3'b000, {(SAMPLE_W - 1){1'b1}}};
    localparam logic signed [HI_W-1:0] SAT_MIN = {3'b111, {(SAMPLE_W - 1){1'b0}}};
    localparam logic signed [PROD_W:0] HALF    = (PROD_W + 1)'(1) << (ENV_W - 1);

    logic signed [PROD_W:0]   rnd_sum;
    logic signed [HI_W-1:0]   rnd_hi;
    logic                     unused_rnd_bits;
    assign rnd_sum = {product[PROD_W-1], product} + HALF;
    assign rnd_hi  = rnd_sum[PROD_W:ENV_W];
    assign unused_rnd_bits = ^rnd_sum[ENV_W-1:0];

    always_comb begin
        if (rnd_hi > SAT_MAX) begin
            scaled = SAT_MAX[SAMPLE_W-1:0];
        end else if (rnd_hi < SAT_MIN) begin
            scaled = SAT_MIN[SAMPLE_W-1:0];
        end else begin
            scaled = rnd_hi[SAMPLE_W-1:0];
        end
    end
`else
    // Taking the bits above ENV_W is an arithmetic shift that truncates toward -inf.
    logic unused_prod_bits;
    assign scaled = product[ENV_W +: SAMPLE_W];
    assign unused_prod_bits = ^{product[PROD_W-1], product[ENV_W-1:0]};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lvl_q        <= '0;
            state_q      <= StIdle;
            gate_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            sample_out_q <= '0;
        end else begin
            lvl_q       <= lvl_d;
            state_q     <= state_d;
            gate_q      <= gate;
            out_valid_q <= in_ready;
            if (in_ready) begin
                sample_out_q <= scaled;
            end
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign env_level  = lvl_q;
    assign env_state  = state_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed testbench for adsr_envelope (SAMPLE_W = ENV_W = RATE_W = 16).
module tb_adsr_envelope;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_ready;
    logic signed [15:0] sample_in;
    logic               gate;
    logic        [15:0] attack_rate, decay_rate, sustain_level, release_rate;
    logic signed [15:0] sample_out;
    logic               out_valid;
    logic        [15:0] env_level;
    logic        [2:0]  env_state;
    logic               busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    adsr_envelope #(
        .SAMPLE_W(16),
        .ENV_W   (16),
        .RATE_W  (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_ready     (in_ready),
        .sample_in    (sample_in),
        .gate         (gate),
        .attack_rate  (attack_rate),
        .decay_rate   (decay_rate),
        .sustain_level(sustain_level),
        .release_rate (release_rate),
        .sample_out   (sample_out),
        .out_valid    (out_valid),
        .env_level    (env_level),
        .env_state    (env_state),
        .busy         (busy)
    );

    logic [15:0] adsr_lvl [9] = '{16'd16384, 16'd32768, 16'd49152, 16'd65535,
                                  16'd57343, 16'd49151, 16'd40959, 16'd32768, 16'd32768};
    logic [2:0]  adsr_st  [9] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3};

    logic signed [15:0] b2b_in  [8] = '{16'sd1000, -16'sd1000, 16'sd3, -16'sd3,
                                        16'sd32767, -16'sd32768, 16'sd0, 16'sd1};
`ifdef ADSR_ROUND_EN
    logic signed [15:0] b2b_exp [8] = '{16'sd500, -16'sd500, 16'sd2, -16'sd1,
                                        16'sd16384, -16'sd16384, 16'sd0, 16'sd1};
    logic signed [15:0] exp_pos_full = 16'sd32767;
    logic signed [15:0] exp_neg_full = -16'sd32767;
`else
    logic signed [15:0] b2b_exp [8] = '{16'sd500, -16'sd500, 16'sd1, -16'sd2,
                                        16'sd16383, -16'sd16384, 16'sd0, 16'sd0};
    logic signed [15:0] exp_pos_full = 16'sd32766;
    logic signed [15:0] exp_neg_full = -16'sd32768;
`endif

    // Stimulus helpers. These only drive inputs; every comparison is made inline by a test.
    task automatic apply_reset();
        reset = 1'b0; in_ready = 1'b0; gate = 1'b0; sample_in = '0;
        attack_rate = '0; decay_rate = '0; sustain_level = '0; release_rate = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic strobe();
        @(negedge clk) in_ready = 1'b1;
        @(posedge clk) #1;
    endtask

    task automatic unstrobe();
        @(negedge clk) in_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        vectors++; if (env_level !== 16'd0) begin miscompares++; $display("FAIL rst_level: got %0d want 0", env_level); end
        vectors++; if (env_state !== 3'd0) begin miscompares++; $display("FAIL rst_state: got %0d want 0", env_state); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        vectors++; if (sample_out !== 16'sd0) begin miscompares++; $display("FAIL rst_sample: got %0d want 0", sample_out); end
        attack_rate = 16'd30000;
        @(negedge clk) gate = 1'b1;
        strobe();
        vectors++; if (env_level !== 16'd30000) begin miscompares++; $display("FAIL rst_pre_level: got %0d want 30000", env_level); end
        vectors++; if (env_state !== 3'd1) begin miscompares++; $display("FAIL rst_pre_state: got %0d want 1", env_state); end
        // Asynchronous reset between clock edges must act at once.
        #2 reset = 1'b0;
        #1;
        vectors++; if (env_level !== 16'd0) begin miscompares++; $display("FAIL rst_async_level: got %0d want 0", env_level); end
        vectors++; if (env_state !== 3'd0) begin miscompares++; $display("FAIL rst_async_state: got %0d want 0", env_state); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_async_valid: got %b want 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        unstrobe();
        gate = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_adsr_run();
        apply_reset();
        attack_rate = 16'd16384; decay_rate = 16'd8192; sustain_level = 16'd32768;
        @(negedge clk) gate = 1'b1;
        @(posedge clk) #1;
        vectors++; if (env_state !== 3'd1 || env_level !== 16'd0) begin miscompares++; $display("FAIL adsr_rise: got st %0d lvl %0d want st 1 lvl 0", env_state, env_level); end
        for (int i = 0; i < 9; i++) begin
            unstrobe();
            strobe();
            vectors++;
            if (env_level !== adsr_lvl[i] || env_state !== adsr_st[i]) begin
                miscompares++;
                $display("FAIL adsr_step%0d: got lvl %0d st %0d want lvl %0d st %0d",
                         i, env_level, env_state, adsr_lvl[i], adsr_st[i]);
            end
        end
        unstrobe();
        gate = 1'b0; release_rate = 16'd16384;
        @(posedge clk) #1;
        vectors++; if (env_state !== 3'd4 || env_level !== 16'd32768) begin miscompares++; $display("FAIL adsr_fall: got st %0d lvl %0d want st 4 lvl 32768", env_state, env_level); end
        unstrobe();
        strobe();
        vectors++; if (env_state !== 3'd4 || env_level !== 16'd16384) begin miscompares++; $display("FAIL adsr_rel1: got st %0d lvl %0d want st 4 lvl 16384", env_state, env_level); end
        unstrobe();
        strobe();
        vectors++; if (env_state !== 3'd0 || env_level !== 16'd0) begin miscompares++; $display("FAIL adsr_rel2: got st %0d lvl %0d want st 0 lvl 0", env_state, env_level); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL adsr_busy: got %b want 0", busy); end
        unstrobe();
    endtask

    task automatic test_scaling();
        apply_reset();
        sustain_level = 16'd65535;
        @(negedge clk) begin gate = 1'b1; in_ready = 1'b1; end
        @(posedge clk) #1;
        vectors++; if (env_state !== 3'd2 || env_level !== 16'd65535) begin miscompares++; $display("FAIL scale_attack: got st %0d lvl %0d want st 2 lvl 65535", env_state, env_level); end
        @(posedge clk) #1;
        vectors++; if (env_state !== 3'd3 || env_level !== 16'd65535) begin miscompares++; $display("FAIL scale_sustain: got st %0d lvl %0d want st 3 lvl 65535", env_state, env_level); end
        unstrobe();
        sample_in = 16'sh7FFF;
        @(posedge clk) #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL scale_idle_valid: got %b want 0", out_valid); end
        @(negedge clk) in_ready = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL scale_early_valid: got %b want 0", out_valid); end
        @(posedge clk) #1;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL scale_pos_valid: got %b want 1", out_valid); end
        vectors++; if (sample_out !== exp_pos_full) begin miscompares++; $display("FAIL scale_pos: got %0d want %0d", sample_out, exp_pos_full); end
        unstrobe();
        sample_in = 16'sh8000;
        @(posedge clk) #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL scale_pulse_width: got %b want 0", out_valid); end
        strobe();
        vectors++; if (out_valid !== 1'b1 || sample_out !== exp_neg_full) begin miscompares++; $display("FAIL scale_neg: got v %b out %0d want v 1 out %0d", out_valid, sample_out, exp_neg_full); end
        unstrobe();
    endtask

    task automatic test_retrigger();
        apply_reset();
        attack_rate = 16'd40000;
        @(negedge clk) gate = 1'b1;
        strobe();
        vectors++; if (env_level !== 16'd40000 || env_state !== 3'd1) begin miscompares++; $display("FAIL retrig_attack: got lvl %0d st %0d want 40000 st 1", env_level, env_state); end
        unstrobe();
        gate = 1'b0; release_rate = 16'd1000;
        @(posedge clk) #1;
        vectors++; if (env_level !== 16'd40000 || env_state !== 3'd4) begin miscompares++; $display("FAIL retrig_fall: got lvl %0d st %0d want 40000 st 4", env_level, env_state); end
        strobe();
        vectors++; if (env_level !== 16'd39000 || env_state !== 3'd4) begin miscompares++; $display("FAIL retrig_release: got lvl %0d st %0d want 39000 st 4", env_level, env_state); end
        unstrobe();
        gate = 1'b1; attack_rate = 16'd1000;
        @(posedge clk) #1;
        vectors++; if (env_level !== 16'd39000 || env_state !== 3'd1) begin miscompares++; $display("FAIL retrig_rise: got lvl %0d st %0d want 39000 st 1", env_level, env_state); end
        strobe();
        vectors++; if (env_level !== 16'd40000 || env_state !== 3'd1) begin miscompares++; $display("FAIL retrig_step: got lvl %0d st %0d want 40000 st 1", env_level, env_state); end
        unstrobe();
    endtask

    task automatic test_coincidence();
        apply_reset();
        @(negedge clk) begin gate = 1'b1; in_ready = 1'b1; end
        @(posedge clk) #1;
        vectors++; if (env_level !== 16'd65535 || env_state !== 3'd2) begin miscompares++; $display("FAIL coin_rise: got lvl %0d st %0d want 65535 st 2", env_level, env_state); end
        // Gate fall together with a strobe at release rate 0 goes straight to IDLE.
        @(negedge clk) gate = 1'b0;
        @(posedge clk) #1;
        vectors++; if (env_level !== 16'd0 || env_state !== 3'd0) begin miscompares++; $display("FAIL coin_fall: got lvl %0d st %0d want 0 st 0", env_level, env_state); end
        unstrobe();
        strobe();
        vectors++; if (env_level !== 16'd0 || env_state !== 3'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL coin_idle: got lvl %0d st %0d busy %b want 0 0 0", env_level, env_state, busy); end
        unstrobe();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        sustain_level = 16'd32768;
        @(negedge clk) begin gate = 1'b1; in_ready = 1'b1; end
        @(posedge clk) #1;
        @(posedge clk) #1;
        vectors++; if (env_level !== 16'd32768 || env_state !== 3'd3) begin miscompares++; $display("FAIL b2b_setup: got lvl %0d st %0d want 32768 st 3", env_level, env_state); end
        unstrobe();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) begin in_ready = 1'b1; sample_in = b2b_in[i]; end
            @(posedge clk) #1;
            vectors++;
            if (out_valid !== 1'b1 || sample_out !== b2b_exp[i]) begin
                miscompares++;
                $display("FAIL b2b_%0d: got v %b out %0d want v 1 out %0d", i, out_valid, sample_out, b2b_exp[i]);
            end
        end
        unstrobe();
        @(posedge clk) #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_tail: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_adsr_run();
        test_scaling();
        test_retrigger();
        test_coincidence();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
